clk_div_prog: RTL and testbench

- Runtime-programmable integer clock divider. Successor to the fixed divide-by-N AON clock generator.
- Produces a divided clock `clk_out` with divisor N, plus single-cycle rise/fall strobes in the `clk` domain.
- Divisor updates are deferred to a period boundary, so a reprogram never produces a runt pulse.
- Feeds the AON/RTC tick (default 16 MHz → 32.787 kHz, N = 488) and any slow peripheral timebase.

---
 rtl/clk_div_prog.sv | 86 ++++++++
 tb/tb_clk_div_prog.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with registered divided clock and
// single-cycle rise/fall strobes; divisor changes take effect only at a period wrap.
module clk_div_prog #(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 488
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             pend,
    output logic [CNT_W-1:0] div_act
);

    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DIV_RESET);

    // Divisors of 0 or 1 are kept as loaded but run as N=2.
    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // Odd divisors give the extra cycle to the low phase.
    function automatic logic [CNT_W-1:0] low_len(input logic [CNT_W-1:0] n);
        return n - (n >> 1);
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] n_cur;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_act_nxt;
    logic [CNT_W-1:0] low_nxt;
    logic             wrap;

    // NOTE: every signal assigned in always_comb gets a default on each path,
    // otherwise synthesis infers a latch.
    always_comb begin
        n_cur       = eff_div(div_act);
        wrap        = en && (cnt == n_cur - ONE);
        cnt_nxt     = cnt;
        div_act_nxt = div_act;
        if (en) begin
            cnt_nxt = wrap ? '0 : cnt + ONE;
        end
        if (wrap && pend) begin
            div_act_nxt = pend_val;
        end
        low_nxt = low_len(eff_div(div_act_nxt));
    end

    // Outputs are registered from the next-state values so clk_out tracks cnt
    // with no extra cycle of latency.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            div_act   <= RST_DIV;
            pend_val  <= '0;
            pend      <= 1'b0;
            clk_out   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            div_act   <= div_act_nxt;
            clk_out   <= (cnt_nxt >= low_nxt);
            tick_rise <= en && (cnt_nxt == low_nxt);
            tick_fall <= wrap;
            // A load on the wrap cycle lands after the old pending value is applied.
            if (div_load) begin
                pend_val <= div_val;
                pend     <= 1'b1;
            end else if (wrap && pend) begin
                pend     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog: reset, default period, deferred
// loads, clamped small divisors, load on wrap, enable freeze and mid-period reset.
module tb_clk_div_prog;

    localparam int CNT_W = 16;

    logic             clk;
    logic             resetn;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick_rise;
    logic             tick_fall;
    logic             pend;
    logic [CNT_W-1:0] div_act;

    int checks = 0;
    int errors = 0;

    clk_div_prog #(.CNT_W(CNT_W), .DIV_RESET(488)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .pend      (pend),
        .div_act   (div_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Apply a one-cycle load strobe at the current cycle.
    task automatic load(input logic [CNT_W-1:0] v);
        div_val  = v;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; en = 1'b1; div_load = 1'b1; div_val = 16'd7;
        step(2);
        div_load = 1'b0;
        checks++;
        if ({clk_out, tick_rise, tick_fall, pend} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs: got %b expected 0000", {clk_out, tick_rise, tick_fall, pend});
        end
        checks++;
        if (div_act !== 16'd488) begin
            errors++;
            $display("FAIL reset_div_act: got %0d expected 488", div_act);
        end
    endtask

    // N=488: 244 low, 244 high, rise at cnt 244, fall at each cnt 0 after a wrap.
    task automatic test_default_period();
        logic [2:0] exp;
        resetn = 1'b1;
        for (int i = 0; i < 976; i++) begin
            exp = {((i % 488) >= 244), ((i % 488) == 244), ((i % 488) == 0) && (i > 0)};
            checks++;
            if ({clk_out, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL default_period cyc %0d: got %b expected %b", i, {clk_out, tick_rise, tick_fall}, exp);
            end
            step(1);
        end
    endtask

    task automatic test_load_deferred();
        logic [2:0] exp;
        step(100);
        load(16'd5);                 // cnt now 101
        checks++;
        if ({pend, div_act} !== {1'b1, 16'd488}) begin
            errors++;
            $display("FAIL deferred_pend: got pend=%b div=%0d expected pend=1 div=488", pend, div_act);
        end
        step(386);                   // cnt 487, last cycle of old period
        checks++;
        if ({pend, clk_out, div_act} !== {1'b1, 1'b1, 16'd488}) begin
            errors++;
            $display("FAIL deferred_hold: got pend=%b clk=%b div=%0d expected 1 1 488", pend, clk_out, div_act);
        end
        step(1);
        checks++;
        if ({pend, div_act} !== {1'b0, 16'd5}) begin
            errors++;
            $display("FAIL deferred_apply: got pend=%b div=%0d expected pend=0 div=5", pend, div_act);
        end
        for (int j = 0; j < 10; j++) begin
            exp = {((j % 5) >= 3), ((j % 5) == 3), ((j % 5) == 0)};
            checks++;
            if ({clk_out, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL n5_pattern cyc %0d: got %b expected %b", j, {clk_out, tick_rise, tick_fall}, exp);
            end
            step(1);
        end
    endtask

    task automatic test_small_div();
        logic [2:0] exp;
        load(16'd1);                 // N=5 period, cnt 1
        step(4);                     // wrap applies 1
        checks++;
        if (div_act !== 16'd1) begin
            errors++;
            $display("FAIL div1_apply: got %0d expected 1", div_act);
        end
        for (int j = 0; j < 6; j++) begin
            exp = {((j % 2) == 1), ((j % 2) == 1), ((j % 2) == 0)};
            checks++;
            if ({clk_out, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL div1_pattern cyc %0d: got %b expected %b", j, {clk_out, tick_rise, tick_fall}, exp);
            end
            step(1);
        end
        load(16'd0);                 // N=2 period, cnt 1
        step(1);
        checks++;
        if ({pend, div_act} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL div0_apply: got pend=%b div=%0d expected pend=0 div=0", pend, div_act);
        end
        for (int j = 0; j < 6; j++) begin
            exp = {((j % 2) == 1), ((j % 2) == 1), ((j % 2) == 0)};
            checks++;
            if ({clk_out, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL div0_pattern cyc %0d: got %b expected %b", j, {clk_out, tick_rise, tick_fall}, exp);
            end
            step(1);
        end
    endtask

    task automatic test_load_on_wrap();
        logic [2:0] exp;
        load(16'd5);                 // N=2, cnt 1
        step(1);                     // N=5, cnt 0
        load(16'd3);                 // cnt 1, pend holds 3
        step(3);                     // cnt 4: wrap cycle
        load(16'd8);                 // apply 3, capture 8
        checks++;
        if ({pend, div_act} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL wrap_load_first: got pend=%b div=%0d expected pend=1 div=3", pend, div_act);
        end
        for (int j = 0; j < 3; j++) begin
            exp = {(j >= 2), (j == 2), (j == 0)};
            checks++;
            if ({clk_out, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL n3_pattern cyc %0d: got %b expected %b", j, {clk_out, tick_rise, tick_fall}, exp);
            end
            step(1);
        end
        checks++;
        if ({pend, div_act} !== {1'b0, 16'd8}) begin
            errors++;
            $display("FAIL wrap_load_second: got pend=%b div=%0d expected pend=0 div=8", pend, div_act);
        end
        for (int j = 0; j < 8; j++) begin
            exp = {(j >= 4), (j == 4), (j == 0)};
            checks++;
            if ({clk_out, tick_rise, tick_fall} !== exp) begin
                errors++;
                $display("FAIL n8_pattern cyc %0d: got %b expected %b", j, {clk_out, tick_rise, tick_fall}, exp);
            end
            step(1);
        end
    endtask

    task automatic test_en_freeze();
        load(16'd6);                 // N=8, cnt 1
        step(7);                     // N=6, cnt 0
        checks++;
        if (div_act !== 16'd6) begin
            errors++;
            $display("FAIL freeze_setup: got %0d expected 6", div_act);
        end
        step(4);                     // cnt 4, high phase
        en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step(1);
            checks++;
            if ({clk_out, tick_rise, tick_fall} !== 3'b100) begin
                errors++;
                $display("FAIL freeze_hold cyc %0d: got %b expected 100", j, {clk_out, tick_rise, tick_fall});
            end
        end
        en = 1'b1;
        step(1);                     // cnt 5
        checks++;
        if ({clk_out, tick_rise, tick_fall} !== 3'b100) begin
            errors++;
            $display("FAIL freeze_resume1: got %b expected 100", {clk_out, tick_rise, tick_fall});
        end
        step(1);                     // wrap, cnt 0
        checks++;
        if ({clk_out, tick_rise, tick_fall} !== 3'b001) begin
            errors++;
            $display("FAIL freeze_resume2: got %b expected 001", {clk_out, tick_rise, tick_fall});
        end
    endtask

    task automatic test_reset_mid();
        load(16'd9);                 // N=6, cnt 1
        step(3);                     // cnt 4
        checks++;
        if ({clk_out, pend} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_pre: got %b expected 11", {clk_out, pend});
        end
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        checks++;
        if ({clk_out, tick_rise, tick_fall, pend, div_act} !== {4'b0000, 16'd488}) begin
            errors++;
            $display("FAIL midreset_post: got %b div=%0d expected 0000 div=488", {clk_out, tick_rise, tick_fall, pend}, div_act);
        end
        step(243);                   // cnt 243
        checks++;
        if ({clk_out, tick_rise} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_low: got %b expected 00", {clk_out, tick_rise});
        end
        step(1);                     // cnt 244
        checks++;
        if ({clk_out, tick_rise, tick_fall} !== 3'b110) begin
            errors++;
            $display("FAIL midreset_rise: got %b expected 110", {clk_out, tick_rise, tick_fall});
        end
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0;
        #1;
        test_reset();
        test_default_period();
        test_load_deferred();
        test_small_div();
        test_load_on_wrap();
        test_en_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
